// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: configurable UART transmitter.
//
// Sends one frame per accepted request. A frame is a start bit (0), DATA_BITS
// data bits LSB first, an optional odd/even parity bit and STOP_BITS stop
// bits (1). Every bit lasts BAUD_DIV clocks.
//
// Parameters:
//   BAUD_DIV  - clocks per bit period (2..65535)
//   DATA_BITS - data bits per frame (5..9)
//   PARITY    - 0 = none, 1 = odd, 2 = even
//   STOP_BITS - stop bits per frame (1 or 2)
//
// Ports:
//   s_clk    - clock, rising edge
//   s_rst_n  - asynchronous active-low reset
//   tx_trig  - single-cycle transmit request, honoured only while tx_busy=0
//   tx_data  - frame payload, captured on an accepted request
//   tx_busy  - high for every cycle of a frame in progress
//   tx_done  - one-cycle pulse in the cycle after the last stop-bit cycle
//   rs232_tx - serial line, idles high
module uart_tx_cfg #(
    parameter int BAUD_DIV  = 434,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 s_clk,
    input  logic                 s_rst_n,
    input  logic                 tx_trig,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic                 rs232_tx
);

    // The bit counter is shared between data bits and stop bits, so it is
    // sized for whichever of the two runs longer.
    localparam int CNT_W   = $clog2(BAUD_DIV);
    localparam int IDX_MAX = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
    localparam int IDX_W   = $clog2(IDX_MAX);

    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(BAUD_DIV - 1);
    localparam logic [IDX_W-1:0] LAST_DATA  = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] LAST_STOP  = IDX_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t                 state, state_n;
    logic [CNT_W-1:0]       baud_cnt, baud_cnt_n;
    logic [IDX_W-1:0]       bit_idx, bit_idx_n;
    logic [DATA_BITS-1:0]   shift_reg, shift_reg_n;
    logic                   par_bit, par_bit_n;
    logic                   line_n, busy_n, done_n;

    // State, counters and all three outputs are registered together; the
    // combinational block computes the value each output takes next cycle,
    // so no input reaches an output without passing through a flop.
    always_ff @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state     <= ST_IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            par_bit   <= 1'b0;
            rs232_tx  <= 1'b1;
            tx_busy   <= 1'b0;
            tx_done   <= 1'b0;
        end else begin
            state     <= state_n;
            baud_cnt  <= baud_cnt_n;
            bit_idx   <= bit_idx_n;
            shift_reg <= shift_reg_n;
            par_bit   <= par_bit_n;
            rs232_tx  <= line_n;
            tx_busy   <= busy_n;
            tx_done   <= done_n;
        end
    end

    // Each bit ends when the down-counter reaches zero; at that boundary the
    // counter is reloaded and the line value for the following bit is
    // selected. The parity bit is computed from the payload at acceptance,
    // since the shift register no longer holds it by the time it is sent.
    always_comb begin
        state_n     = state;
        baud_cnt_n  = baud_cnt;
        bit_idx_n   = bit_idx;
        shift_reg_n = shift_reg;
        par_bit_n   = par_bit;
        line_n      = 1'b1;
        busy_n      = 1'b1;
        done_n      = 1'b0;

        case (state)
            ST_IDLE: begin
                busy_n = 1'b0;
                if (tx_trig) begin
                    state_n     = ST_START;
                    baud_cnt_n  = CNT_RELOAD;
                    bit_idx_n   = '0;
                    shift_reg_n = tx_data;
                    par_bit_n   = (PARITY == 1) ? ~(^tx_data) : (^tx_data);
                    line_n      = 1'b0;
                    busy_n      = 1'b1;
                end
            end

            ST_START: begin
                line_n = 1'b0;
                if (baud_cnt == '0) begin
                    state_n    = ST_DATA;
                    baud_cnt_n = CNT_RELOAD;
                    line_n     = shift_reg[0];
                end else begin
                    baud_cnt_n = baud_cnt - 1'b1;
                end
            end

            ST_DATA: begin
                line_n = shift_reg[0];
                if (baud_cnt == '0) begin
                    baud_cnt_n = CNT_RELOAD;
                    if (bit_idx == LAST_DATA) begin
                        bit_idx_n = '0;
                        if (PARITY != 0) begin
                            state_n = ST_PARITY;
                            line_n  = par_bit;
                        end else begin
                            state_n = ST_STOP;
                            line_n  = 1'b1;
                        end
                    end else begin
                        bit_idx_n   = bit_idx + 1'b1;
                        shift_reg_n = shift_reg >> 1;
                        line_n      = shift_reg[1];
                    end
                end else begin
                    baud_cnt_n = baud_cnt - 1'b1;
                end
            end

            ST_PARITY: begin
                line_n = par_bit;
                if (baud_cnt == '0) begin
                    state_n    = ST_STOP;
                    baud_cnt_n = CNT_RELOAD;
                    bit_idx_n  = '0;
                    line_n     = 1'b1;
                end else begin
                    baud_cnt_n = baud_cnt - 1'b1;
                end
            end

            ST_STOP: begin
                line_n = 1'b1;
                if (baud_cnt == '0) begin
                    if (bit_idx == LAST_STOP) begin
                        state_n   = ST_IDLE;
                        bit_idx_n = '0;
                        busy_n    = 1'b0;
                        done_n    = 1'b1;
                    end else begin
                        bit_idx_n  = bit_idx + 1'b1;
                        baud_cnt_n = CNT_RELOAD;
                    end
                end else begin
                    baud_cnt_n = baud_cnt - 1'b1;
                end
            end

            default: begin
                state_n = ST_IDLE;
                busy_n  = 1'b0;
            end
        endcase
    end

endmodule
